ifm_line_bank_buf: RTL and testbench

Parametrised input-feature-map line buffer. It selects one of NUM_BANK row BRAMs in round-robin order and streams BUF_DEPTH consecutive words from the selected bank into a window shift register. It presents the window to the convolution datapath with a valid/ready handshake. Two window-advance modes are supported: full refill and slide-by-one. The block replaces the fixed 4-bank selector paired with a separate read/write buffer. It sits between the IFM row BRAMs and the PE array input.

---
 rtl/ifm_line_bank_buf_if.sv | 29 ++
 rtl/ifm_line_bank_buf.sv | 115 +++++++++++
 tb/tb_ifm_line_bank_buf.sv | 268 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/ifm_line_bank_buf_if.sv
// Bus between the IFM row BRAM banks, the line-bank window buffer and the PE array input.
// The master side drives the control inputs; the slave side is the buffer itself.
interface ifm_line_bank_buf_if #(
  parameter int RAM_WIDTH = 64,
  parameter int BUF_DEPTH = 11,
  parameter int NUM_BANK  = 4,
  parameter int BANK_W    = 2
);
  logic                           start;
  logic [RAM_WIDTH*NUM_BANK-1:0]  ifm_bram_data;
  logic [NUM_BANK-1:0]            ifm_bram_full;
  logic                           height_hs;
  logic                           slide_mode;
  logic                           buf_ready;
  logic [NUM_BANK-1:0]            read_en;
  logic [BANK_W-1:0]              bank_sel;
  logic [RAM_WIDTH*BUF_DEPTH-1:0] buf_data;
  logic                           buf_full;

  modport master (
    output start, ifm_bram_data, ifm_bram_full, height_hs, slide_mode, buf_ready,
    input  read_en, bank_sel, buf_data, buf_full
  );

  modport slave (
    input  start, ifm_bram_data, ifm_bram_full, height_hs, slide_mode, buf_ready,
    output read_en, bank_sel, buf_data, buf_full
  );
endinterface

// File: rtl/ifm_line_bank_buf.sv
// Round-robin IFM line buffer: streams BUF_DEPTH words from the selected row BRAM into a
// window shift register and hands the window to the PE array with refill or slide-by-one advance.
module ifm_line_bank_buf #(
  parameter int RAM_WIDTH = 64,
  parameter int BUF_DEPTH = 11,
  parameter int NUM_BANK  = 4,
  parameter int BANK_W    = 2
) (
  input  logic                 clk,
  input  logic                 rst_na,
  ifm_line_bank_buf_if.slave   bus
);

  localparam int                 CNT_W     = $clog2(BUF_DEPTH + 1);
  localparam int                 WIN_W     = RAM_WIDTH * BUF_DEPTH;
  localparam logic [CNT_W-1:0]   DEPTH_C   = CNT_W'(BUF_DEPTH);
  localparam logic [CNT_W-1:0]   DEPTH_M1  = CNT_W'(BUF_DEPTH - 1);
  localparam logic [BANK_W-1:0]  LAST_BANK = BANK_W'(NUM_BANK - 1);

  typedef enum logic [1:0] {IDLE, FILL, HOLD} state_e;

  state_e               state_q, state_d;
  logic [CNT_W-1:0]     count_q, count_d;
  logic                 rd_pend_q, rd_pend_d;
  logic [BANK_W-1:0]    bank_q, bank_d;
  logic [WIN_W-1:0]     buf_data_q, buf_data_d;
  logic                 buf_full_q, buf_full_d;

  logic                 handshake;
  logic                 capture;
  logic                 rd_issue;
  logic [CNT_W:0]       occupancy;
  logic [RAM_WIDTH-1:0] word;
  logic [NUM_BANK-1:0]  read_en;

  // Occupancy includes the in-flight read so the window is never over-requested.
  always_comb begin
    handshake = buf_full_q && bus.buf_ready;
    occupancy = {1'b0, count_q} + {{CNT_W{1'b0}}, rd_pend_q};
    rd_issue  = (state_q == FILL) && bus.ifm_bram_full[bank_q] &&
                (occupancy < {1'b0, DEPTH_C}) && !bus.height_hs;
    capture   = rd_pend_q && !bus.height_hs;
    word      = bus.ifm_bram_data[int'(bank_q)*RAM_WIDTH +: RAM_WIDTH];
  end

  always_comb begin
    count_d    = count_q;
    rd_pend_d  = rd_issue;
    bank_d     = bank_q;
    buf_data_d = buf_data_q;

    if (bus.height_hs) begin
      bank_d = (bank_q == LAST_BANK) ? '0 : bank_q + BANK_W'(1);
    end

    // An abort outranks both the handshake and any capture landing in the same cycle.
    if (bus.height_hs && (state_q != IDLE)) begin
      count_d = '0;
    end else if (handshake) begin
      count_d = bus.slide_mode ? DEPTH_M1 : '0;
    end else if (capture) begin
      count_d    = count_q + CNT_W'(1);
      buf_data_d = {buf_data_q[WIN_W-RAM_WIDTH-1:0], word};
    end

    buf_full_d = (count_d == DEPTH_C);
  end

  always_ff @(posedge clk) begin
    if (!rst_na) begin
      count_q    <= '0;
      rd_pend_q  <= 1'b0;
      bank_q     <= '0;
      buf_data_q <= '0;
      buf_full_q <= 1'b0;
    end else begin
      count_q    <= count_d;
      rd_pend_q  <= rd_pend_d;
      bank_q     <= bank_d;
      buf_data_q <= buf_data_d;
      buf_full_q <= buf_full_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_na) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (bus.start) state_d = FILL;
      FILL: if (!bus.height_hs && (count_d == DEPTH_C)) state_d = HOLD;
      HOLD: if (bus.height_hs || handshake) state_d = FILL;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    read_en = '0;
    if (rd_issue) begin
      read_en[bank_q] = 1'b1;
    end
  end

  assign bus.read_en  = read_en;
  assign bus.bank_sel = bank_q;
  assign bus.buf_data = buf_data_q;
  assign bus.buf_full = buf_full_q;

endmodule

// File: tb/tb_ifm_line_bank_buf.sv
// Bench for ifm_line_bank_buf: BRAM bank model, window scoreboard and cycle-accurate
// checks of fill, slide, bank rotation, abort, flow control and reset.
module tb_ifm_line_bank_buf;

  localparam int RW = 64;
  localparam int BD = 11;
  localparam int NB = 4;
  localparam int BW = 2;
  localparam int WW = RW * BD;

  logic clk;
  logic rst_na;

  int checks = 0;
  int errors = 0;

  logic [WW-1:0] expected_q[$];
  logic [WW-1:0] exp_win;
  int            bram_addr[NB];

  ifm_line_bank_buf_if #(.RAM_WIDTH(RW), .BUF_DEPTH(BD), .NUM_BANK(NB), .BANK_W(BW)) bus();
  ifm_line_bank_buf_if #(.RAM_WIDTH(RW), .BUF_DEPTH(BD), .NUM_BANK(3), .BANK_W(2)) bus_b();

  ifm_line_bank_buf #(.RAM_WIDTH(RW), .BUF_DEPTH(BD), .NUM_BANK(NB), .BANK_W(BW)) dut (
    .clk(clk), .rst_na(rst_na), .bus(bus)
  );

  ifm_line_bank_buf #(.RAM_WIDTH(RW), .BUF_DEPTH(BD), .NUM_BANK(3), .BANK_W(2)) dut_b (
    .clk(clk), .rst_na(rst_na), .bus(bus_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [RW-1:0] bramWord(input int bank, input int addr);
    return {32'(bank), 32'(addr)};
  endfunction

  // Window holding words first..first+BD-1 of a bank: oldest on top, newest at bottom.
  function automatic logic [WW-1:0] expWindow(input int bank, input int first);
    logic [WW-1:0] w = '0;
    for (int i = 0; i < BD; i++) w[(BD-1-i)*RW +: RW] = bramWord(bank, first + i);
    return w;
  endfunction

  task automatic checkOutput(input string tag, input logic [WW-1:0] obs, input logic [WW-1:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input logic hs, input logic ready, input logic slide);
    tick();
    bus.height_hs  = hs;
    bus.buf_ready  = ready;
    bus.slide_mode = slide;
  endtask

  task automatic waitFull(input string tag, input int exp_cycles);
    int got = -1;
    for (int c = 1; c <= 64; c++) begin
      tick();
      @(negedge clk);
      if (bus.buf_full) begin
        got = c;
        break;
      end
    end
    checkOutput(tag, got, exp_cycles);
  endtask

  task automatic consume(input logic slide);
    applyStimulus(1'b0, 1'b1, slide);
    applyStimulus(1'b0, 1'b0, 1'b0);
  endtask

  task automatic expectOneHot(input string tag, input int bank);
    logic [NB-1:0] oh = '0;
    oh[bank] = 1'b1;
    @(negedge clk);
    checkOutput({tag, "_bank"}, bus.bank_sel, bank);
    checkOutput({tag, "_read_en"}, bus.read_en, oh);
  endtask

  // Row BRAMs with one-cycle read latency; each row restarts at address 0 on height_hs.
  always @(posedge clk) begin
    if (!rst_na) begin
      bus.ifm_bram_data <= '0;
      for (int k = 0; k < NB; k++) bram_addr[k] <= 0;
    end else begin
      for (int k = 0; k < NB; k++) begin
        if (bus.height_hs) begin
          bram_addr[k] <= 0;
        end else if (bus.read_en[k]) begin
          bus.ifm_bram_data[k*RW +: RW] <= bramWord(k, bram_addr[k]);
          bram_addr[k] <= bram_addr[k] + 1;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_na && bus.buf_full && bus.buf_ready) begin
      if (expected_q.size() == 0) begin
        checkOutput("sb_unexpected_window", 1, 0);
      end else begin
        exp_win = expected_q.pop_front();
        checkOutput("sb_window", bus.buf_data, exp_win);
      end
    end
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int bank;
    bus.start = 1'b0;  bus.ifm_bram_full = '1;  bus.height_hs = 1'b0;
    bus.slide_mode = 1'b0;  bus.buf_ready = 1'b0;
    bus_b.start = 1'b0;  bus_b.ifm_bram_full = '1;  bus_b.height_hs = 1'b0;
    bus_b.slide_mode = 1'b0;  bus_b.buf_ready = 1'b0;  bus_b.ifm_bram_data = '0;
    rst_na = 1'b0;
    tick();
    tick();
    @(negedge clk);
    checkOutput("reset_buf_full", bus.buf_full, 0);
    checkOutput("reset_read_en", bus.read_en, 0);
    checkOutput("reset_bank_sel", bus.bank_sel, 0);
    checkOutput("reset_buf_data", bus.buf_data, 0);
    tick();
    rst_na = 1'b1;

    // Basic fill from bank 0
    tick();
    bus.start = 1'b1;
    expected_q.push_back(expWindow(0, 0));
    tick();
    bus.start = 1'b0;
    for (int i = 0; i < BD; i++) begin
      @(negedge clk);
      checkOutput("fill_read_en", bus.read_en, 4'b0001);
      tick();
    end
    @(negedge clk);
    checkOutput("fill_read_stop", bus.read_en, 0);
    checkOutput("fill_not_early", bus.buf_full, 0);
    tick();
    @(negedge clk);
    checkOutput("fill_latency", bus.buf_full, 1);

    // Slide by one with the consumer always ready
    expected_q.push_back(expWindow(0, 1));
    expected_q.push_back(expWindow(0, 2));
    expected_q.push_back(expWindow(0, 3));
    applyStimulus(1'b0, 1'b1, 1'b1);
    waitFull("slide_period_a", 3);
    waitFull("slide_period_b", 3);
    applyStimulus(1'b0, 1'b0, 1'b1);
    waitFull("slide_period_c", 2);

    // height_hs coincident with a slide handshake forces a full refill from the next bank
    applyStimulus(1'b1, 1'b1, 1'b1);
    @(negedge clk);
    checkOutput("bank_sel_lag", bus.bank_sel, 0);
    applyStimulus(1'b0, 1'b0, 1'b1);
    expectOneHot("coincident", 1);
    checkOutput("coincident_full_drop", bus.buf_full, 0);
    expected_q.push_back(expWindow(1, 0));
    waitFull("coincident_refill", 12);
    consume(1'b0);

    // Bank rotation
    bank = 1;
    for (int i = 0; i < 5; i++) begin
      applyStimulus(1'b1, 1'b0, 1'b0);
      @(negedge clk);
      checkOutput("hs_read_gate", bus.read_en, 0);
      applyStimulus(1'b0, 1'b0, 1'b0);
      bank = (bank + 1) % NB;
      expectOneHot("rotate", bank);
      if (i < 4) begin
        applyStimulus(1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0);
      end
    end
    expected_q.push_back(expWindow(2, 0));
    waitFull("rotation_refill", 12);
    consume(1'b0);

    // Abort at count 5 with a read pending
    repeat (5) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("abort_read_gate", bus.read_en, 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    expectOneHot("abort", 3);
    checkOutput("abort_full_low", bus.buf_full, 0);
    expected_q.push_back(expWindow(3, 0));
    waitFull("abort_refill", 12);
    consume(1'b0);

    // Flow control: bank 0 loses its full flag for 4 cycles after the third read
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    expectOneHot("flow_start", 0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    bus.ifm_bram_full = 4'b1110;
    @(negedge clk);
    checkOutput("flow_stall", bus.read_en, 0);
    repeat (3) applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    bus.ifm_bram_full = '1;
    @(negedge clk);
    checkOutput("flow_resume", bus.read_en, 4'b0001);
    expected_q.push_back(expWindow(0, 0));
    waitFull("flow_latency", 9);
    consume(1'b0);

    // Reset in the middle of a fill from bank 1
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    rst_na = 1'b0;
    tick();
    @(negedge clk);
    checkOutput("midfill_reset_data", bus.buf_data, 0);
    checkOutput("midfill_reset_full", bus.buf_full, 0);
    checkOutput("midfill_reset_read_en", bus.read_en, 0);
    checkOutput("midfill_reset_bank", bus.bank_sel, 0);
    tick();
    rst_na = 1'b1;

    // height_hs while idle only moves the bank pointer
    applyStimulus(1'b1, 1'b0, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0);
    @(negedge clk);
    checkOutput("idle_hs_bank", bus.bank_sel, 1);
    checkOutput("idle_hs_read_en", bus.read_en, 0);

    // Three-bank instance wraps 2 -> 0
    for (int i = 0; i < 4; i++) begin
      tick();
      bus_b.height_hs = 1'b1;
      tick();
      bus_b.height_hs = 1'b0;
      @(negedge clk);
      checkOutput("wrap3_bank", bus_b.bank_sel, (i + 1) % 3);
      checkOutput("wrap3_read_en", bus_b.read_en, 0);
    end

    checkOutput("sb_drained", expected_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
